pc_sequencer: RTL and testbench

Program-counter register and fetch-request generator for the RISC-V core. It consumes the pc+4 value from the PC incrementer and drives `pc` back to it. It also issues fetch requests to instruction memory with a valid/ready handshake. Branch/jump redirects arriving while a request is stalled are held and applied once the request completes.

---
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Keeps the program counter and issues instruction-fetch requests with a
//   valid/ready handshake. The incremented address (pc+4) is computed outside
//   this block and fed back in on pc_plus_4. A branch or jump that arrives
//   while a request is stalled is held and applied once the request completes.
//
// Optional build macro: PC_MISALIGN_CHECK_EN
//   When defined, a redirect target with nonzero low bits is dropped. The pc
//   takes the sequential path instead, and misaligned pulses for one cycle.
//   When undefined, targets load unchecked and misaligned is tied 0.
//
// Ports
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   pc_plus_4        in   [WIDTH] sequential next address (pc+4)
//   redirect         in   branch taken / jump this cycle
//   redirect_target  in   [WIDTH] target address, valid with redirect
//   stall            in   core hazard, suppresses new requests
//   fetch_ready      in   instruction memory accepts the current request
//   pc               out  [WIDTH] current fetch address (registered)
//   fetch_valid      out  request valid (registered)
//   redirect_pending out  a redirect is held behind the current handshake
//   misaligned       out  one-cycle pulse on a dropped misaligned target
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_plus_4,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic             fetch_valid,
  output logic             redirect_pending,
  output logic             misaligned
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             fv_q, fv_d;
  logic             pend_q, pend_d;

  logic             fire;
  logic             held;
  logic [WIDTH-1:0] seq_pc;
  logic             redir_ok;
  logic             pend_ok;

  assign fire   = fv_q & fetch_ready;
  // Outstanding request: pc, valid and the handshake are frozen until accepted.
  assign held   = fv_q & ~fetch_ready;
  assign seq_pc = fire ? pc_plus_4 : pc_q;

`ifdef PC_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign redir_ok = (redirect_target[1:0] == 2'b00);
  assign pend_ok  = (pend_tgt_q[1:0] == 2'b00);

  // Pulse in the cycle after a direct or pending target is dropped.
  always_comb begin
    mis_d = 1'b0;
    if (state_q == ST_BOOT) begin
      mis_d = redirect & ~redir_ok;
    end else if (!held) begin
      mis_d = redirect ? ~redir_ok : (pend_q & ~pend_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end

  assign misaligned = mis_q;
`else
  assign redir_ok   = 1'b1;
  assign pend_ok    = 1'b1;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fv_d       = fv_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;

    case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset; a redirect here retargets the first fetch.
        state_d = ST_RUN;
        fv_d    = 1'b0;
        if (redirect && redir_ok) pc_d = redirect_target;
      end

      default: begin
        if (held) begin
          // Stall is ignored while a request is outstanding. The newest redirect wins.
          if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_target;
          end
        end else begin
          // Priority: live redirect, then held redirect, then sequential.
          // A dropped target falls back to the sequential path.
          if (redirect && redir_ok) begin
            pc_d = redirect_target;
          end else if (!redirect && pend_q && pend_ok) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = seq_pc;
          end
          pend_d = 1'b0;
          fv_d   = ~stall;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      fv_q       <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fv_q       <= fv_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc               = pc_q;
  assign fetch_valid      = fv_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [31:0] MIS_EXP_PC  = CHECK_EN ? 32'h0000_0054 : 32'h0000_0102;
  localparam logic [31:0] MIS_EXP_PC2 = CHECK_EN ? 32'h0000_0058 : 32'h0000_0106;

  logic        clk;
  logic        rst;
  logic [31:0] pc_plus_4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        redirect_pending;
  logic        misaligned;

  int checks;
  int failures;

  // Reference state
  logic [31:0] m_pc, m_ptgt;
  logic        m_fv, m_pend, m_mis, m_boot;

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_plus_4        (pc_plus_4),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .stall            (stall),
    .fetch_ready      (fetch_ready),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .redirect_pending (redirect_pending),
    .misaligned       (misaligned)
  );

  // External incrementer
  assign pc_plus_4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tgt_ok(input logic [31:0] t);
    return (t[1:0] == 2'b00) || !CHECK_EN;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r_rst, input logic r_redir, input logic [31:0] r_tgt,
                              input logic r_stall, input logic r_rdy);
    logic [31:0] nxt;
    if (r_rst) begin
      m_pc = 32'h0; m_fv = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0; m_mis = 1'b0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_fv   = 1'b0;
      m_mis  = r_redir && !tgt_ok(r_tgt);
      if (r_redir && tgt_ok(r_tgt)) m_pc = r_tgt;
    end else if (m_fv && !r_rdy) begin
      m_mis = 1'b0;
      if (r_redir) begin
        m_pend = 1'b1;
        m_ptgt = r_tgt;
      end
    end else begin
      nxt   = m_fv ? m_pc + 32'd4 : m_pc;
      m_mis = 1'b0;
      if (r_redir) begin
        if (tgt_ok(r_tgt)) nxt = r_tgt;
        else               m_mis = 1'b1;
      end else if (m_pend) begin
        if (tgt_ok(m_ptgt)) nxt = m_ptgt;
        else                m_mis = 1'b1;
      end
      m_pc   = nxt;
      m_pend = 1'b0;
      m_fv   = !r_stall;
    end
  endtask

  task automatic step(input logic r_rst, input logic r_redir, input logic [31:0] r_tgt,
                      input logic r_stall, input logic r_rdy);
    rst             = r_rst;
    redirect        = r_redir;
    redirect_target = r_tgt;
    stall           = r_stall;
    fetch_ready     = r_rdy;
    @(posedge clk);
    model_update(r_rst, r_redir, r_tgt, r_stall, r_rdy);
    #1;
    chk("model_pc", pc, m_pc);
    chk("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
    chk("model_redirect_pending", {31'b0, redirect_pending}, {31'b0, m_pend});
    chk("model_misaligned", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  initial begin
    logic        r_rst, r_redir, r_stall, r_rdy;
    logic [31:0] r_tgt;
    checks = 0;
    failures = 0;

    // Reset state
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pend", {31'b0, redirect_pending}, 32'h0);

    // First request two cycles after reset release, then one fetch per cycle
    step(0, 0, 0, 0, 1);
    chk("boot_fv", {31'b0, fetch_valid}, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("first_fv", {31'b0, fetch_valid}, 32'h1);
    chk("seq_pc0", pc, 32'h0);
    step(0, 0, 0, 0, 1);  chk("seq_pc4", pc, 32'h4);
    step(0, 0, 0, 0, 1);  chk("seq_pc8", pc, 32'h8);
    step(0, 0, 0, 0, 1);  chk("seq_pcC", pc, 32'hC);
    step(0, 0, 0, 0, 1);  chk("seq_pc10", pc, 32'h10);

    // Outstanding request holds pc and valid
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_pc", pc, 32'h10);
      chk("hold_fv", {31'b0, fetch_valid}, 32'h1);
    end
    step(0, 0, 0, 0, 1);  chk("release_pc", pc, 32'h14);

    // Redirect held behind a stalled handshake
    step(0, 1, 32'h20, 0, 1);   chk("goto20", pc, 32'h20);
    step(0, 1, 32'h100, 0, 0);
    chk("pend_set", {31'b0, redirect_pending}, 32'h1);
    chk("pend_pc_hold", pc, 32'h20);
    step(0, 0, 0, 0, 1);
    chk("pend_apply_pc", pc, 32'h100);
    chk("pend_clear", {31'b0, redirect_pending}, 32'h0);

    // Redirect on fire beats pc+4; newest pending target wins
    step(0, 1, 32'h40, 0, 1);   chk("goto40", pc, 32'h40);
    step(0, 1, 32'h200, 0, 1);  chk("fire_redir", pc, 32'h200);
    step(0, 1, 32'h300, 0, 0);
    step(0, 1, 32'h400, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("pend_overwrite", pc, 32'h400);

    // Stall, redirect while idle, wrap-around
    step(0, 0, 0, 1, 1);
    chk("stall_fv", {31'b0, fetch_valid}, 32'h0);
    step(0, 1, 32'h80, 1, 1);
    chk("idle_redir_pc", pc, 32'h80);
    chk("idle_redir_nopend", {31'b0, redirect_pending}, 32'h0);
    step(0, 0, 0, 0, 1);
    chk("unstall_fv", {31'b0, fetch_valid}, 32'h1);
    step(0, 1, 32'hFFFF_FFFC, 0, 1);  chk("goto_top", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);              chk("wrap", pc, 32'h0);

    // Misaligned target
    step(0, 1, 32'h50, 0, 1);   chk("goto50", pc, 32'h50);
    step(0, 1, 32'h102, 0, 1);
    chk("mis_pc", pc, MIS_EXP_PC);
    chk("mis_pulse", {31'b0, misaligned}, {31'b0, CHECK_EN});
    step(0, 0, 0, 0, 1);
    chk("mis_pc2", pc, MIS_EXP_PC2);
    chk("mis_drop", {31'b0, misaligned}, 32'h0);

    // Reset during an outstanding request
    step(0, 0, 0, 0, 0);
    step(1, 1, 32'h700, 0, 0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_fv", {31'b0, fetch_valid}, 32'h0);

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      r_rst   = ($urandom_range(0, 99) < 2);
      r_redir = ($urandom_range(0, 3) == 0);
      r_tgt   = $urandom;
      if ($urandom_range(0, 7) != 0) r_tgt[1:0] = 2'b00;
      r_stall = ($urandom_range(0, 4) == 0);
      r_rdy   = ($urandom_range(0, 9) < 6);
      step(r_rst, r_redir, r_tgt, r_stall, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
